reg_op_scheduler: RTL and testbench
===================================

// Module: reg_op_scheduler
// PURPOSE
//  Arbitrates two requesters for one shared Register32bit-style register (E/FunSel/I control).
//  Single ops: passes the requester's 3-bit FunSel and 32-bit operand to the register for one cycle.
//  Burst ops: sequences BURST_BYTES shift-in-byte ops (FunSel=110) to assemble a word MSB-first.
//  Sits between the control unit or DMA-style requesters and the register's control inputs.
// PARAMETERS
//  BURST_BYTES  4  beats per burst op; legal range 1..4
//  PRIO_FIXED   0  0 = round-robin between requesters; 1 = requester 0 always wins
// PORTS
//  Clock        in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   2   bit i = requester i has an op pending
//  req_burst    in   2   bit i = op is a byte burst (req_cmd ignored)
//  req_cmd      in   6   {cmd1,cmd0}, 3-bit FunSel per requester
//  req_data     in   64  {data1,data0}, 32-bit operand per requester
//  req_ready    out  2   bit i = op from requester i accepted this edge if valid
//  reg_E        out  1   register enable, registered
//  reg_FunSel   out  3   register function select, registered
//  reg_I        out  32  register data input, registered
//  busy         out  1   high in ISSUE/BURST/DONE
//  grant_id     out  1   requester owning the current op
//  done         out  1   one-cycle pulse: the register now holds the op result
//  done_id      out  1   requester whose op completed; valid with done
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, reg_E=0, reg_FunSel=000, reg_I=0, busy=0, done=0,
//   done_id=0, grant_id=0, beat count=0, last_grant=1 (requester 0 wins first).
//  States: IDLE -> ISSUE (single) | BURST (burst) -> DONE -> IDLE.
//  IDLE: winner is computed combinationally. One valid wins outright. If both are valid:
//   PRIO_FIXED=1 gives req 0; otherwise the requester != last_grant wins.
//   req_ready[winner]=1 only in IDLE; both ready bits are 0 in every other state.
//  Accept edge (valid&ready): capture cmd/data/burst/id; update last_grant and grant_id.
//   Single: reg_E=1, reg_FunSel=cmd, reg_I=data; enter ISSUE.
//   Burst: reg_E=1, reg_FunSel=110, reg_I={24'b0,data[8*BURST_BYTES-1 -: 8]}; enter BURST.
//  ISSUE: one cycle with reg_E=1; the register captures at the next edge, then DONE.
//  BURST: beat k (0-based) drives byte data[8*(BURST_BYTES-k)-1 -: 8] for exactly one cycle.
//   After beat BURST_BYTES-1, enter DONE. reg_E stays high for BURST_BYTES consecutive cycles.
//  DONE: reg_E=0, done=1, done_id=grant_id for one cycle, then IDLE.
//   Throughput: single op every 3 cycles; burst every BURST_BYTES+2 cycles.
//  Latency: accept edge k -> register updated at edge k+1 (single) or k+BURST_BYTES (burst).
//   The done pulse appears in the cycle after that update.
//  Operands are captured at accept. Requester inputs are don't-care afterwards.
//   Dropping valid before ready is legal: no op is issued.
//  reg_E=0 in IDLE and DONE. reg_FunSel and reg_I hold their last values when reg_E=0.
//  Reset mid-op aborts without a done pulse; register contents are not restored.
//   After reset, the next accept starts at beat 0.
//  Burst with BURST_BYTES=1 behaves as a one-beat burst: low byte loaded via 110.
// TESTING
//  1 Single: req0 valid, cmd=010, data=0x00001234 -> ready0 same cycle; next cycle
//    reg_E=1/FunSel=010/I=0x1234 for exactly 1 cycle; then done=1, done_id=0, register Q=0x1234.
//  2 Burst: req1 burst, data=0xDEADBEEF -> 4 cycles FunSel=110, I=0xDE,0xAD,0xBE,0xEF;
//    done_id=1 and register Q=0xDEADBEEF on the done cycle.
//  3 Round-robin: both valid continuously with single ops -> grant order 0,1,0,1;
//    one accept every 3 cycles.
//  4 Fixed priority (PRIO_FIXED=1): both valid -> req0 wins every accept;
//    req1 is granted only once req0 drops valid.
//  5 Reset mid-burst: pulse rst during beat 2 -> reg_E=0 and busy=0 without waiting for an edge;
//    no done pulse; with both valid afterwards, req0 wins and the burst restarts at 0xDE.
//  6 Busy hold-off: req0 valid during a req1 burst -> ready0=0 until IDLE;
//    accepted on the first IDLE cycle.

Source files
------------

// File: rtl/reg_op_scheduler.sv
// Two-requester scheduler driving the E/FunSel/I controls of a shared 32-bit register.
// Single ops pass through for one cycle; burst ops shift a word in MSB-first, one byte per beat.
module reg_op_scheduler #(
    parameter int BURST_BYTES = 4,
    parameter bit PRIO_FIXED  = 1'b0
) (
    input  logic        Clock,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_burst,
    input  logic [5:0]  req_cmd,
    input  logic [63:0] req_data,
    output logic [1:0]  req_ready,
    output logic        reg_E,
    output logic [2:0]  reg_FunSel,
    output logic [31:0] reg_I,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic        done_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

    localparam logic [2:0] SHIFT_BYTE = 3'b110;
    localparam logic [2:0] LAST_BEAT  = 3'(BURST_BYTES - 1);

    state_t      state, state_n;
    logic        e_n;
    logic [2:0]  fs_n;
    logic [31:0] i_n;
    logic [31:0] data_q, data_n;
    logic [2:0]  cnt, cnt_n;
    logic        last, last_n;
    logic        gid_n, did_n;
    logic        win;
    logic [2:0]  win_cmd;
    logic [31:0] win_data;
    logic        accept;

    // Beat k carries byte BURST_BYTES-1-k of the operand (MSB first).
    function automatic logic [7:0] beat_byte(input logic [31:0] d,
                                             input logic [2:0]  k);
        return 8'(d >> (8 * (BURST_BYTES - 1 - int'(k))));
    endfunction

    always_comb begin
        win = 1'b0;
        unique case (req_valid)
            2'b11:   win = PRIO_FIXED ? 1'b0 : ~last;
            2'b10:   win = 1'b1;
            default: win = 1'b0;
        endcase
    end

    assign win_cmd   = win ? req_cmd[5:3] : req_cmd[2:0];
    assign win_data  = win ? req_data[63:32] : req_data[31:0];
    assign accept    = (state == IDLE) && (|req_valid);
    assign req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_n = state;
        e_n     = reg_E;
        fs_n    = reg_FunSel;
        i_n     = reg_I;
        data_n  = data_q;
        cnt_n   = cnt;
        last_n  = last;
        gid_n   = grant_id;
        did_n   = done_id;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    last_n = win;
                    gid_n  = win;
                    e_n    = 1'b1;
                    if (req_burst[win]) begin
                        fs_n    = SHIFT_BYTE;
                        data_n  = win_data;
                        i_n     = {24'b0, beat_byte(win_data, 3'd0)};
                        cnt_n   = 3'd0;
                        state_n = BURST;
                    end else begin
                        fs_n    = win_cmd;
                        i_n     = win_data;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                e_n     = 1'b0;
                did_n   = grant_id;
                state_n = DONE;
            end
            BURST: begin
                if (cnt == LAST_BEAT) begin
                    e_n     = 1'b0;
                    did_n   = grant_id;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 3'd1;
                    i_n   = {24'b0, beat_byte(data_q, cnt + 3'd1)};
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            reg_E      <= 1'b0;
            reg_FunSel <= 3'b000;
            reg_I      <= 32'b0;
            data_q     <= 32'b0;
            cnt        <= 3'd0;
            last       <= 1'b1;
            grant_id   <= 1'b0;
            done_id    <= 1'b0;
        end else begin
            state      <= state_n;
            reg_E      <= e_n;
            reg_FunSel <= fs_n;
            reg_I      <= i_n;
            data_q     <= data_n;
            cnt        <= cnt_n;
            last       <= last_n;
            grant_id   <= gid_n;
            done_id    <= did_n;
        end
    end

endmodule

// File: tb/tb_reg_op_scheduler.sv
// Bench for reg_op_scheduler: vector table, scoreboard on done pulses, and
// hand sequences for round-robin, hold-off, mid-burst reset and fixed priority.
module tb_reg_op_scheduler;

    logic        Clock;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_burst;
    logic [5:0]  req_cmd;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        reg_E;
    logic [2:0]  reg_FunSel;
    logic [31:0] reg_I;
    logic        busy;
    logic        grant_id;
    logic        done;
    logic        done_id;

    logic [1:0]  fx_ready;
    logic        fx_E;
    logic [2:0]  fx_FunSel;
    logic [31:0] fx_I;
    logic        fx_busy;
    logic        fx_grant_id;
    logic        fx_done;
    logic        fx_done_id;

    reg_op_scheduler dut (
        .Clock      (Clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_burst  (req_burst),
        .req_cmd    (req_cmd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_E      (reg_E),
        .reg_FunSel (reg_FunSel),
        .reg_I      (reg_I),
        .busy       (busy),
        .grant_id   (grant_id),
        .done       (done),
        .done_id    (done_id)
    );

    reg_op_scheduler #(.PRIO_FIXED(1'b1)) dut_fx (
        .Clock      (Clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_burst  (req_burst),
        .req_cmd    (req_cmd),
        .req_data   (req_data),
        .req_ready  (fx_ready),
        .reg_E      (fx_E),
        .reg_FunSel (fx_FunSel),
        .reg_I      (fx_I),
        .busy       (fx_busy),
        .grant_id   (fx_grant_id),
        .done       (fx_done),
        .done_id    (fx_done_id)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  burst;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        id;
        logic [2:0]  fs;
        logic [31:0] i;
        logic [31:0] q;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] q;
    } exp_t;

    vec_t        vt[8];
    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        sb_on;
    logic [31:0] model_q;
    logic [7:0]  bb[4];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    // Downstream register: 010 loads, 110 shifts a byte in, others hold.
    always @(posedge Clock) begin
        if (reg_E) begin
            case (reg_FunSel)
                3'b010:  model_q <= reg_I;
                3'b110:  model_q <= {model_q[23:0], reg_I[7:0]};
                default: model_q <= model_q;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (sb_on && done) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 id=%0d expected no done at %0t",
                         done_id, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_id", 32'(done_id), 32'(e.id));
                chk("reg_q", model_q, e.q);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] b,
                         input logic [2:0] c0, input logic [2:0] c1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_burst = b;
        req_cmd   = {c1, c0};
        req_data  = {d1, d0};
    endtask

    task automatic wait_idle(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic push(input logic id, input logic [31:0] q);
        exp_t e;
        e.id = id;
        e.q  = q;
        sbq.push_back(e);
    endtask

    initial begin
        int n;
        int lastc;
        logic exp_id;

        sb_on   = 1'b1;
        model_q = 32'h0;
        rst     = 1'b1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        bb[0] = 8'hDE; bb[1] = 8'hAD; bb[2] = 8'hBE; bb[3] = 8'hEF;

        vt[0] = '{2'b01, 2'b00, 3'b010, 3'b000, 32'h00001234, 32'h0,
                  1'b0, 3'b010, 32'h00001234, 32'h00001234};
        vt[1] = '{2'b10, 2'b10, 3'b000, 3'b000, 32'h0, 32'hDEADBEEF,
                  1'b1, 3'b110, 32'h000000DE, 32'hDEADBEEF};
        vt[2] = '{2'b11, 2'b00, 3'b010, 3'b010, 32'h0F0F0F0F, 32'h11111111,
                  1'b0, 3'b010, 32'h0F0F0F0F, 32'h0F0F0F0F};
        vt[3] = '{2'b11, 2'b00, 3'b010, 3'b010, 32'h22222222, 32'h33333333,
                  1'b1, 3'b010, 32'h33333333, 32'h33333333};
        vt[4] = '{2'b10, 2'b00, 3'b000, 3'b011, 32'h0, 32'hFFFFFFFF,
                  1'b1, 3'b011, 32'hFFFFFFFF, 32'h33333333};
        vt[5] = '{2'b11, 2'b01, 3'b000, 3'b010, 32'h89ABCDEF, 32'h0,
                  1'b0, 3'b110, 32'h00000089, 32'h89ABCDEF};
        vt[6] = '{2'b11, 2'b10, 3'b010, 3'b000, 32'h00000077, 32'h00000080,
                  1'b1, 3'b110, 32'h00000000, 32'h00000080};
        vt[7] = '{2'b01, 2'b00, 3'b010, 3'b000, 32'hFFFFFFFF, 32'h0,
                  1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF};

        #12;
        chk("rst_E", 32'(reg_E), 32'd0);
        chk("rst_FunSel", 32'(reg_FunSel), 32'd0);
        chk("rst_I", reg_I, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        @(negedge Clock);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            @(posedge Clock); #1;
            drive(vt[k].valid, vt[k].burst, vt[k].c0, vt[k].c1,
                  vt[k].d0, vt[k].d1);
            push(vt[k].id, vt[k].q);
            @(negedge Clock);
            chk($sformatf("v%0d_ready", k), 32'(req_ready),
                32'(vt[k].id ? 2'b10 : 2'b01));
            @(posedge Clock); #1;
            drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
            @(negedge Clock);
            chk($sformatf("v%0d_E", k), 32'(reg_E), 32'd1);
            chk($sformatf("v%0d_FunSel", k), 32'(reg_FunSel), 32'(vt[k].fs));
            chk($sformatf("v%0d_I", k), reg_I, vt[k].i);
            chk($sformatf("v%0d_grant", k), 32'(grant_id), 32'(vt[k].id));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
            wait_idle($sformatf("v%0d_idle", k));
        end

        // Burst beats from requester 1, checked cycle by cycle.
        @(posedge Clock); #1;
        drive(2'b10, 2'b10, 3'b000, 3'b000, 32'h0, 32'hDEADBEEF);
        push(1'b1, 32'hDEADBEEF);
        @(negedge Clock);
        chk("burst_ready", 32'(req_ready), 32'h2);
        @(posedge Clock); #1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            chk($sformatf("beat%0d_E", k), 32'(reg_E), 32'd1);
            chk($sformatf("beat%0d_FunSel", k), 32'(reg_FunSel), 32'h6);
            chk($sformatf("beat%0d_I", k), reg_I, {24'h0, bb[k]});
            chk($sformatf("beat%0d_done", k), 32'(done), 32'd0);
        end
        @(negedge Clock);
        chk("burst_done", 32'(done), 32'd1);
        chk("burst_done_E", 32'(reg_E), 32'd0);
        chk("burst_hold_FunSel", 32'(reg_FunSel), 32'h6);
        chk("burst_hold_I", reg_I, 32'h000000EF);
        wait_idle("burst_idle");

        // Round-robin with both requesters continuously valid.
        @(posedge Clock); #1;
        drive(2'b11, 2'b00, 3'b010, 3'b010, 32'hA5A50000, 32'h5A5A1111);
        n = 0;
        lastc = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge Clock);
            if (|(req_ready & req_valid)) begin
                exp_id = n[0];
                chk($sformatf("rr_id%0d", n), 32'(req_ready),
                    32'(exp_id ? 2'b10 : 2'b01));
                if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(c - lastc), 32'd3);
                push(exp_id, exp_id ? 32'h5A5A1111 : 32'hA5A50000);
                lastc = c;
                n++;
            end
        end
        chk("rr_accepts", 32'(n), 32'd4);
        @(posedge Clock); #1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        wait_idle("rr_idle");

        // Requester 0 held off during a requester 1 burst.
        @(posedge Clock); #1;
        drive(2'b10, 2'b10, 3'b000, 3'b000, 32'h0, 32'hCAFEF00D);
        push(1'b1, 32'hCAFEF00D);
        @(negedge Clock);
        chk("hold_first_ready", 32'(req_ready), 32'h2);
        @(posedge Clock); #1;
        drive(2'b01, 2'b00, 3'b010, 3'b000, 32'h00005A5A, 32'h0);
        push(1'b0, 32'h00005A5A);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            chk($sformatf("hold_ready%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
        end
        @(negedge Clock);
        chk("hold_release_ready", 32'(req_ready), 32'h1);
        chk("hold_release_busy", 32'(busy), 32'd0);
        @(posedge Clock); #1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        wait_idle("hold_idle");

        // Reset during beat 2 aborts the burst without a done pulse.
        @(posedge Clock); #1;
        drive(2'b01, 2'b01, 3'b000, 3'b000, 32'hDEADBEEF, 32'h0);
        @(negedge Clock);
        chk("abort_ready", 32'(req_ready), 32'h1);
        @(posedge Clock); #1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        chk("abort_beat2_I", reg_I, 32'h000000BE);
        #1 rst = 1'b1;
        #1;
        chk("abort_async_E", 32'(reg_E), 32'd0);
        chk("abort_async_busy", 32'(busy), 32'd0);
        chk("abort_async_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        @(posedge Clock); #1;
        drive(2'b11, 2'b11, 3'b000, 3'b000, 32'hDEADBEEF, 32'h11223344);
        push(1'b0, 32'hDEADBEEF);
        @(negedge Clock);
        chk("restart_ready", 32'(req_ready), 32'h1);
        chk("restart_no_done", 32'(done), 32'd0);
        @(posedge Clock); #1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        @(negedge Clock);
        chk("restart_E", 32'(reg_E), 32'd1);
        chk("restart_I", reg_I, 32'h000000DE);
        wait_idle("restart_idle");
        @(negedge Clock);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        // Fixed priority instance: requester 0 wins until it drops valid.
        sb_on = 1'b0;
        @(negedge Clock) rst = 1'b1;
        @(negedge Clock) rst = 1'b0;
        @(posedge Clock); #1;
        drive(2'b11, 2'b00, 3'b010, 3'b010, 32'h01010101, 32'h02020202);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge Clock);
            if (|(fx_ready & req_valid)) begin
                chk($sformatf("fx_grant%0d", n), 32'(fx_ready),
                    (n < 3) ? 32'd1 : 32'd2);
                n++;
                if (n == 3) begin
                    @(posedge Clock); #1;
                    req_valid = 2'b10;
                end
            end
        end
        chk("fx_accepts", 32'(n), 32'd4);
        @(posedge Clock); #1;
        drive(2'b00, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0);
        repeat (4) @(negedge Clock);
        chk("fx_idle", 32'(fx_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
